pipelined_hybrid_adder: RTL
===========================

# pipelined_hybrid_adder

Parametrised, pipelined successor to the 8-bit hybrid adder: WIDTH-bit add/subtract built from BLK-bit carry-lookahead blocks rippled together, cut into STAGES register stages. Takes one operation per cycle through a valid/ready handshake with full backpressure, and returns sum, carry, signed-overflow and zero flags. Sits between the KGPRisc operand-read stage and ALU writeback as the wide-adder datapath.

## Interface
- WIDTH, 32, operand/result width; multiple of BLK*STAGES
- BLK, 4, bits per carry-lookahead block
- STAGES, 2, pipeline register stages (≥1); latency in cycles
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted this cycle when in_valid && in_ready
- a, b  in  WIDTH  operands
- cy_in  in  1  carry in (ignored when sub=1)
- sub  in  1  0: a+b+cy_in; 1: a+~b+1 (a−b)
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result when out_valid && out_ready
- sum  out  WIDTH  result
- cy_out  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow = carry into MSB xor carry out
- zero  out  1  sum == 0

## Operation
- Stage s (0..STAGES−1) adds slice [s*W/S +: W/S] using W/(BLK*S) CLA blocks rippled; carry in = stage 0: (sub ? 1 : cy_in), else registered carry from stage s−1.
- Operands for upper slices are carried forward (skewed) in stage registers; lower sum bits delayed so the full sum aligns at the last stage. b inverted at entry when sub=1.
- Last stage registers sum, cy_out, ovf (from carry into bit WIDTH−1), zero.
- Each stage has a valid bit. Stage advances when its successor is empty or advancing; last stage advances when out_ready. in_ready = stage 0 empty or advancing (combinational, no path from in_valid).
- No transfer of any kind while rst_n low.

## Timing
- Reset: all stage valids 0; out_valid=0, sum=0, cy_out=0, ovf=0, zero=0; in_ready=1 (pipeline empty).
- Latency: accept at edge k → out_valid with result after edge k+STAGES−1 (visible in cycle k+STAGES−1... i.e. STAGES edges incl. accept edge), absent stalls.
- Throughput: 1 op/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, sum/flags/out_valid held stable; upstream bubbles collapse; in_ready falls only when all STAGES slots are full.
- Simultaneous: full pipeline with out_ready=1 and in_valid=1 accepts and retires same cycle.
- Reset mid-operation: all in-flight operations discarded, outputs return to reset values immediately (async).
- STAGES=1: single-register adder, latency 1.

## Structure
- Package hybrid_adder_pkg: default WIDTH/BLK/STAGES constants, stage-record typedef (valid, operand slices, partial sum, carry, sub).
- Sub-module cla_block: combinational BLK-bit carry-lookahead (a, b, cin → s, cout, carry into MSB); instantiated W/BLK times via generate.
- Elaboration check: WIDTH % (BLK*STAGES) == 0, else error.

## Test plan
- WIDTH=8, BLK=4, STAGES=2: a=0x6E, b=0xE6, cy_in=1, sub=0 → sum=0x55, cy_out=1, ovf=0, zero=0, out_valid 2 edges after accept.
- Same config: sub=1, a=0x05, b=0x07 → sum=0xFE, cy_out=0, ovf=0; a=0x7F, b=0x01, cy_in=0, sub=0 → sum=0x80, ovf=1; a=0xFF, b=0x01 → sum=0x00, cy_out=1, zero=1.
- Backpressure: 4 back-to-back ops, out_ready low 3 cycles after first out_valid → outputs stable while stalled, in_ready low once 2 slots full, all 4 results delivered in order, none lost/duplicated.
- Reset mid-operation: rst_n low with 2 ops in flight → out_valid=0 and flags 0 at once; after release, first new op's result is the only one seen.
- WIDTH=32, STAGES∈{1,2,4}: 10k random ops, random in_valid/out_ready, scoreboard vs (WIDTH+1)-bit behavioural sum; STAGES=1 latency 1.

Source files
------------

// File: rtl/pipelined_hybrid_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hybrid_adder_pkg
// Description : Shared constants and types for the pipelined hybrid adder.
//               Holds the default geometry (WIDTH / BLK / STAGES) and a
//               record describing one pipeline stage slot in the default
//               configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package hybrid_adder_pkg;

    localparam int c_DEF_WIDTH  = 32;
    localparam int c_DEF_BLK    = 4;
    localparam int c_DEF_STAGES = 2;

    // One in-flight operation as it sits in a stage register: remaining
    // operand bits, the sum bits produced so far and the carry to pass on.
    typedef struct packed {
        logic                   valid;
        logic                   sub;
        logic                   carry;
        logic [c_DEF_WIDTH-1:0] opa;
        logic [c_DEF_WIDTH-1:0] opb;
        logic [c_DEF_WIDTH-1:0] psum;
    } stage_rec_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_hybrid_adder_cla_block.sv
`default_nettype none
// ============================================================================
// Module      : cla_block
// Description : Combinational BLK-bit carry-lookahead adder block. Every
//               internal carry is formed directly from generate/propagate
//               terms and the block carry-in.
// Ports       : a, b   - BLK-bit operands
//               cin    - carry into bit 0
//               s      - BLK-bit sum
//               cout   - carry out of bit BLK-1
//               c_msb  - carry into bit BLK-1 (used for signed overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module cla_block
    import hybrid_adder_pkg::*;
#(
    parameter int BLK = c_DEF_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           c_msb
);

    logic [BLK-1:0] w_g;
    logic [BLK-1:0] w_p;
    logic [BLK:0]   w_c;

    // Carry into bit n as a flat sum of products:
    //   c[n] = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]cin
    function automatic logic lookahead(input logic [BLK-1:0] g,
                                       input logic [BLK-1:0] p,
                                       input logic           ci,
                                       input int             n);
        logic term;
        logic acc;
        term = ci;
        for (int k = 0; k < n; k++) term = term & p[k];
        acc = term;
        for (int j = 0; j < n; j++) begin
            term = g[j];
            for (int k = j + 1; k < n; k++) term = term & p[k];
            acc = acc | term;
        end
        return acc;
    endfunction

    always_comb begin
        w_g = a & b;
        w_p = a ^ b;
        w_c = '0;
        for (int i = 0; i <= BLK; i++) w_c[i] = lookahead(w_g, w_p, cin, i);
    end

    assign s     = w_p ^ w_c[BLK-1:0];
    assign cout  = w_c[BLK];
    assign c_msb = w_c[BLK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_hybrid_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_hybrid_adder
// Description : WIDTH-bit add/subtract built from BLK-bit carry-lookahead
//               blocks rippled together and cut into STAGES register stages.
//               Stage s adds slice [s*W/S +: W/S]; upper operand bits travel
//               forward with the operation, lower sum bits accumulate so the
//               full result lines up in the last stage. valid/ready handshake
//               with full backpressure, one operation per cycle.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid / in_ready  - input handshake
//               a, b, cy_in, sub     - operands, carry-in, subtract select
//               out_valid / out_ready- output handshake
//               sum, cy_out, ovf,zero- registered result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_hybrid_adder
    import hybrid_adder_pkg::*;
#(
    parameter int WIDTH  = c_DEF_WIDTH,
    parameter int BLK    = c_DEF_BLK,
    parameter int STAGES = c_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy_out,
    output logic             ovf,
    output logic             zero
);

    localparam int c_SW = WIDTH / STAGES;   // bits added per stage
    localparam int c_NB = c_SW / BLK;       // CLA blocks per stage

    if ((STAGES < 1) || (BLK < 1) || ((WIDTH % (BLK * STAGES)) != 0)) begin : g_cfg_check
        $error("pipelined_hybrid_adder: WIDTH must be a multiple of BLK*STAGES");
    end

    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] w_en;     // stage register may take new content
    logic [STAGES-1:0] w_vin;    // valid presented to each stage register
    logic [STAGES-1:0] w_load;   // a real operation enters the stage
    logic              w_cmsb;
    logic              w_last_ovf;
    logic              w_last_zero;
    logic              ovf_d;
    logic              ovf_q;
    logic              zero_d;
    logic              zero_q;

    // A stage can take new content when any slot from it to the output is
    // empty, or the output is being drained. Written in closed form so the
    // enables depend only on flops and out_ready.
    for (genvar s = 0; s < STAGES; s++) begin : g_en
        assign w_en[s] = out_ready || !(&valid_q[STAGES-1:s]);
    end

    always_comb begin
        w_vin   = STAGES'({valid_q, in_valid});
        w_load  = w_en & w_vin;
        valid_d = (w_en & w_vin) | (~w_en & valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_LO  = s * c_SW;        // lowest bit added here
        localparam int c_REM = WIDTH - c_LO;    // operand bits still pending

        logic [c_REM-1:0]     w_opa;
        logic [c_REM-1:0]     w_opb;
        logic                 w_cin;
        logic [c_SW-1:0]      w_slice;
        logic [c_LO+c_SW-1:0] w_full;
        logic                 w_cout;
        logic [c_LO+c_SW-1:0] sum_d;
        logic [c_LO+c_SW-1:0] sum_q;
        logic                 carry_d;
        logic                 carry_q;

        // Stage 0 takes the raw operands (b inverted for subtract); later
        // stages take what the previous stage register carried forward.
        if (s == 0) begin : g_src
            assign w_opa  = a;
            assign w_opb  = b ^ {WIDTH{sub}};
            assign w_cin  = sub | cy_in;
            assign w_full = w_slice;
        end else begin : g_src
            assign w_opa  = g_stage[s-1].g_fwd.opa_q;
            assign w_opb  = g_stage[s-1].g_fwd.opb_q;
            assign w_cin  = g_stage[s-1].carry_q;
            assign w_full = {w_slice, g_stage[s-1].sum_q};
        end

        for (genvar j = 0; j < c_NB; j++) begin : g_blk
            logic w_ci;
            logic w_co;
            logic w_cm;

            if (j == 0) begin : g_ci
                assign w_ci = w_cin;
            end else begin : g_ci
                assign w_ci = g_blk[j-1].w_co;
            end

            cla_block #(
                .BLK (BLK)
            ) u_cla (
                .a     (w_opa[j*BLK +: BLK]),
                .b     (w_opb[j*BLK +: BLK]),
                .cin   (w_ci),
                .s     (w_slice[j*BLK +: BLK]),
                .cout  (w_co),
                .c_msb (w_cm)
            );

            // Only the very top block's carry-into-MSB matters (overflow).
            if ((s == STAGES - 1) && (j == c_NB - 1)) begin : g_msb
                assign w_cmsb = w_cm;
            end else begin : g_msb
                logic w_unused_cm;
                assign w_unused_cm = w_cm;
            end
        end

        assign w_cout = g_blk[c_NB-1].w_co;

        always_comb begin
            sum_d   = sum_q;
            carry_d = carry_q;
            if (w_load[s]) begin
                sum_d   = w_full;
                carry_d = w_cout;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        // Operand bits above this stage's slice ride along to the next stage.
        if (c_REM > c_SW) begin : g_fwd
            logic [c_REM-c_SW-1:0] opa_d;
            logic [c_REM-c_SW-1:0] opa_q;
            logic [c_REM-c_SW-1:0] opb_d;
            logic [c_REM-c_SW-1:0] opb_q;

            always_comb begin
                opa_d = opa_q;
                opb_d = opb_q;
                if (w_load[s]) begin
                    opa_d = w_opa[c_REM-1:c_SW];
                    opb_d = w_opb[c_REM-1:c_SW];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        if (s == STAGES - 1) begin : g_last
            assign w_last_ovf  = w_cout ^ w_cmsb;
            assign w_last_zero = ~|w_full;
        end
    end

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (w_load[STAGES-1]) begin
            ovf_d  = w_last_ovf;
            zero_d = w_last_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cy_out    = g_stage[STAGES-1].carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire
